// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-ported unified memory between fetch (IF) and load/store (LS),
// sequencing each access through a fixed-latency synchronous memory.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int LATENCY      = 1,
  parameter int MAX_LS_BURST = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_done,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                ls_req,
  input  logic                ls_we,
  input  logic [DATA_W/8-1:0] ls_be,
  input  logic [ADDR_W-1:0]   ls_addr,
  input  logic [DATA_W-1:0]   ls_wdata,
  output logic                ls_done,
  output logic [DATA_W-1:0]   ls_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                stall,
  output logic                busy
);

  localparam int BE_W    = DATA_W / 8;
  localparam int CNT_W   = $clog2(LATENCY + 1);
  localparam int BURST_W = $clog2(MAX_LS_BURST + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]         state;
  logic [CNT_W-1:0]   cnt;
  logic [BURST_W-1:0] burst;
  logic               owner_ls;
  logic               burst_full;
  logic               grant_ls;
  logic               grant_if;

  // LS normally wins; once it has taken MAX_LS_BURST grants in a row while IF waited, IF goes next.
  assign burst_full = (burst == BURST_W'(MAX_LS_BURST));
  assign grant_ls   = (state == ST_IDLE) && ls_req && !(if_req && burst_full);
  assign grant_if   = (state == ST_IDLE) && !grant_ls && if_req;

  assign busy  = (state != ST_IDLE);
  assign stall = (if_req & ~if_done) | (ls_req & ~ls_done);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      owner_ls  <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_done   <= 1'b0;
      ls_done   <= 1'b0;
      if_rdata  <= '0;
      ls_rdata  <= '0;
    end else begin
      mem_en  <= 1'b0;
      if_done <= 1'b0;
      ls_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant_ls) begin
            owner_ls  <= 1'b1;
            mem_en    <= 1'b1;
            mem_we    <= ls_we;
            mem_be    <= ls_be;
            mem_addr  <= ls_addr;
            mem_wdata <= ls_wdata;
            state     <= ST_ISSUE;
          end else if (grant_if) begin
            owner_ls  <= 1'b0;
            mem_en    <= 1'b1;
            mem_we    <= 1'b0;
            mem_be    <= {BE_W{1'b1}};
            mem_addr  <= if_addr;
            mem_wdata <= '0;
            state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          cnt   <= CNT_W'(LATENCY);
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          // The read word is valid exactly LATENCY cycles after mem_en; capture it on the last one.
          if (cnt == CNT_W'(1)) begin
            state <= ST_DONE;
            if (owner_ls) begin
              ls_done  <= 1'b1;
              ls_rdata <= mem_we ? '0 : mem_rdata;
            end else begin
              if_done  <= 1'b1;
              if_rdata <= mem_rdata;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Counts LS grants taken while IF was waiting; any IF grant or an idle cycle without IF clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      burst <= '0;
    end else if (state == ST_IDLE) begin
      if (grant_if || !if_req) begin
        burst <= '0;
      end else if (grant_ls && !burst_full) begin
        burst <= burst + BURST_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: timeline-based reference model,
// randomized requesters, and directed scenarios with hand-computed expectations.
module tb_mem_port_arbiter;

  localparam int ADDR_W       = 32;
  localparam int DATA_W       = 32;
  localparam int LATENCY      = 2;
  localparam int MAX_LS_BURST = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, ls_req, ls_we;
  logic [31:0] if_addr, ls_addr, ls_wdata;
  logic [3:0]  ls_be;
  logic        if_done, ls_done, mem_en, mem_we, stall, busy;
  logic [31:0] if_rdata, ls_rdata, mem_addr, mem_wdata;
  logic [31:0] mem_rdata = 32'h0;
  logic [3:0]  mem_be;

  mem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LATENCY(LATENCY), .MAX_LS_BURST(MAX_LS_BURST)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_be(ls_be), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_done(ls_done), .ls_rdata(ls_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .stall(stall), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory: read data is only meaningful in the cycle exactly LATENCY after mem_en; otherwise junk.
  logic [31:0] mem     [256];
  logic [31:0] ref_mem [256];
  logic [31:0] mdata;
  int          mage = -1;
  always @(negedge clk) begin
    if (mem_en) begin
      mdata = mem[mem_addr[9:2]];
      if (mem_we)
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) mem[mem_addr[9:2]][b*8 +: 8] = mem_wdata[b*8 +: 8];
      mage = 0;
    end else if (mage >= 0) begin
      mage++;
    end
    mem_rdata = (mage == LATENCY && !mem_en) ? mdata : $urandom;
  end

  task automatic setWord(input logic [31:0] addr, input logic [31:0] val);
    mem[addr[9:2]]     = val;
    ref_mem[addr[9:2]] = val;
  endtask

  // Reference model: an access occupies a fixed timeline (issue, LATENCY waits, done, idle).
  int          phase = 0;
  int          mburst = 0;
  bit          own_ls;
  logic [31:0] e_addr, e_wdata, e_data;
  logic        e_we;
  logic [3:0]  e_be;
  string       model_log = "";

  always @(negedge clk) begin
    logic exp_if_done, exp_ls_done;
    if (!rst_n) begin
      phase  = 0;
      mburst = 0;
      checkOutput("rst_mem_en", mem_en, 0);
      checkOutput("rst_if_done", if_done, 0);
      checkOutput("rst_ls_done", ls_done, 0);
      checkOutput("rst_if_rdata", if_rdata, 0);
      checkOutput("rst_ls_rdata", ls_rdata, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_mem_addr", mem_addr, 0);
      checkOutput("rst_mem_we", mem_we, 0);
      checkOutput("rst_stall", stall, if_req | ls_req);
    end else begin
      exp_if_done = (phase == LATENCY + 2) && !own_ls;
      exp_ls_done = (phase == LATENCY + 2) && own_ls;
      checkOutput("mem_en", mem_en, phase == 1);
      checkOutput("busy", busy, phase != 0);
      checkOutput("if_done", if_done, exp_if_done);
      checkOutput("ls_done", ls_done, exp_ls_done);
      checkOutput("stall", stall, (if_req & ~exp_if_done) | (ls_req & ~exp_ls_done));
      if (phase == 1) begin
        checkOutput("mem_addr", mem_addr, e_addr);
        checkOutput("mem_we", mem_we, e_we);
        checkOutput("mem_be", mem_be, e_be);
        if (e_we) checkOutput("mem_wdata", mem_wdata, e_wdata);
      end
      if (exp_if_done) checkOutput("if_rdata", if_rdata, e_data);
      if (exp_ls_done) checkOutput("ls_rdata", ls_rdata, e_data);

      if (phase == 0) begin
        if (ls_req && !(if_req && mburst == MAX_LS_BURST)) begin
          own_ls = 1'b1;
          e_addr = ls_addr; e_we = ls_we; e_be = ls_be; e_wdata = ls_wdata;
          mburst = if_req ? ((mburst < MAX_LS_BURST) ? mburst + 1 : mburst) : 0;
        end else if (if_req) begin
          own_ls = 1'b0;
          e_addr = if_addr; e_we = 1'b0; e_be = 4'hf; e_wdata = 32'h0;
          mburst = 0;
        end else begin
          mburst = 0;
        end
        if (ls_req || if_req) begin
          phase = 1;
          model_log = {model_log, own_ls ? "L" : "I"};
          if (e_we) begin
            e_data = 32'h0;
            for (int b = 0; b < 4; b++)
              if (e_be[b]) ref_mem[e_addr[9:2]][b*8 +: 8] = e_wdata[b*8 +: 8];
          end else begin
            e_data = ref_mem[e_addr[9:2]];
          end
        end
      end else if (phase == LATENCY + 2) begin
        phase = 0;
      end else begin
        phase++;
      end
    end
  end

  function automatic logic [31:0] randAddr();
    return 32'($urandom_range(0, 255)) << 2;
  endfunction

  task automatic applyStimulus(input int ncyc);
    for (int k = 0; k < ncyc; k++) begin
      @(posedge clk); #1;
      if (!if_req || if_done) begin
        if ($urandom_range(0, 2) == 0) begin
          if_req = 1'b1; if_addr = randAddr();
        end else begin
          if_req = 1'b0;
        end
      end
      if (!ls_req || ls_done) begin
        if ($urandom_range(0, 1) == 0) begin
          ls_req = 1'b1; ls_addr = randAddr(); ls_we = 1'($urandom);
          ls_be = 4'($urandom); ls_wdata = $urandom;
        end else begin
          ls_req = 1'b0;
        end
      end
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #1;
      if (if_done) if_req = 1'b0;
      if (ls_done) ls_req = 1'b0;
      if (!if_req && !ls_req) break;
    end
    checkOutput("drain_idle", {30'h0, if_req, ls_req}, 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  int          n, r, en_cyc, done_cyc, dcnt, got;
  logic [31:0] cap_rdata, cap_addr, cap_wdata;
  logic        cap_we;
  logic [3:0]  cap_be;
  logic [31:0] en_addrs [8];
  int          en_cycs  [8];
  string       pat;

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]     = $urandom;
      ref_mem[i] = mem[i];
    end
    rst_n = 1'b0; if_req = 0; ls_req = 0; ls_we = 0; ls_be = 0;
    if_addr = 0; ls_addr = 0; ls_wdata = 0;

    // Reset with toggling requests
    repeat (5) begin
      @(posedge clk); #1;
      if_req = 1'($urandom); ls_req = 1'($urandom); if_addr = randAddr(); ls_addr = randAddr();
    end
    if_req = 1'b1; ls_req = 1'b0; #1;
    checkOutput("pin_rst_stall", stall, 1);
    checkOutput("pin_rst_mem_en", mem_en, 0);
    @(posedge clk); #1;
    if_req = 0; ls_req = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // IF read of 0x100 returning 0xDEADBEEF
    setWord(32'h100, 32'hDEADBEEF);
    @(posedge clk); #1;
    n = cyc; if_addr = 32'h100; if_req = 1'b1;
    en_cyc = -1; done_cyc = -1; dcnt = 0; cap_we = 1'bx; cap_addr = 'x; cap_rdata = 'x;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (mem_en) begin en_cyc = cyc; cap_addr = mem_addr; cap_we = mem_we; end
      if (if_done) begin done_cyc = cyc; dcnt++; cap_rdata = if_rdata; if_req = 1'b0; end
    end
    checkOutput("pin_if_en_cycle", en_cyc, n + 1);
    checkOutput("pin_if_en_addr", cap_addr, 32'h100);
    checkOutput("pin_if_en_we", cap_we, 0);
    checkOutput("pin_if_done_cycle", done_cyc, n + 4);
    checkOutput("pin_if_rdata", cap_rdata, 32'hDEADBEEF);
    checkOutput("pin_if_done_once", dcnt, 1);

    // Simultaneous requests: LS first, IF exactly LATENCY+3 later
    @(posedge clk); #1;
    if_addr = 32'h300; ls_addr = 32'h10; ls_we = 1'b0; if_req = 1'b1; ls_req = 1'b1;
    got = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (mem_en && got < 8) begin en_addrs[got] = mem_addr; en_cycs[got] = cyc; got++; end
      if (ls_done) ls_req = 1'b0;
      if (if_done) begin if_req = 1'b0; break; end
    end
    checkOutput("pin_both_count", got, 2);
    if (got >= 2) begin
      checkOutput("pin_both_first_ls", en_addrs[0], 32'h10);
      checkOutput("pin_both_second_if", en_addrs[1], 32'h300);
      checkOutput("pin_both_spacing", en_cycs[1] - en_cycs[0], LATENCY + 3);
    end
    drain();

    // Anti-starvation order with both requests held
    model_log = "";
    pat = "LLILLI";
    @(posedge clk); #1;
    if_req = 1'b1; ls_req = 1'b1;
    got = 0;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk); #1;
      if (mem_en && got < 8) begin en_addrs[got] = mem_addr; got++; end
      if (got >= 6 && if_done) begin if_req = 1'b0; ls_req = 1'b0; break; end
    end
    checkOutput("pin_burst_count", got, 6);
    for (int i = 0; i < 6 && i < got; i++)
      checkOutput($sformatf("pin_burst_grant%0d", i), en_addrs[i],
                  (pat[i] == "L") ? 32'h10 : 32'h300);
    checks++;
    if (model_log != pat) begin
      errors++;
      $display("[TB] FAIL model_burst_order: got %s expected %s", model_log, pat);
    end
    drain();

    // Partial store then read-back
    setWord(32'h200, 32'hAABBCCDD);
    @(posedge clk); #1;
    ls_addr = 32'h200; ls_we = 1'b1; ls_be = 4'b0011; ls_wdata = 32'h12345678; ls_req = 1'b1;
    cap_we = 1'bx; cap_be = 'x; cap_addr = 'x; cap_wdata = 'x; cap_rdata = 'x;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (mem_en) begin cap_we = mem_we; cap_be = mem_be; cap_addr = mem_addr; cap_wdata = mem_wdata; end
      if (ls_done) begin cap_rdata = ls_rdata; ls_req = 1'b0; break; end
    end
    checkOutput("pin_st_we", cap_we, 1);
    checkOutput("pin_st_be", cap_be, 4'b0011);
    checkOutput("pin_st_addr", cap_addr, 32'h200);
    checkOutput("pin_st_wdata", cap_wdata, 32'h12345678);
    checkOutput("pin_st_rdata", cap_rdata, 0);
    @(posedge clk); #1;
    ls_we = 1'b0; ls_req = 1'b1; cap_rdata = 'x;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (ls_done) begin cap_rdata = ls_rdata; ls_req = 1'b0; break; end
    end
    checkOutput("pin_ld_after_st", cap_rdata, 32'hAABB5678);
    drain();

    // Reset during WAIT, then restart of the held request
    @(posedge clk); #1;
    if_addr = 32'h40; if_req = 1'b1; got = 0;
    for (int k = 0; k < 10 && got == 0; k++) begin
      @(posedge clk); #1;
      if (mem_en) got = 1;
    end
    @(posedge clk); #1;
    rst_n = 1'b0; #1;
    checkOutput("pin_rst_mid_busy", busy, 0);
    checkOutput("pin_rst_mid_stall", stall, 1);
    dcnt = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (if_done) dcnt++;
    end
    rst_n = 1'b1; r = cyc; en_cyc = -1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (mem_en && en_cyc < 0) en_cyc = cyc;
      if (if_done) begin if_req = 1'b0; break; end
    end
    checkOutput("pin_rst_no_done", dcnt, 0);
    checkOutput("pin_restart_issue", en_cyc, r + 1);
    drain();

    // Randomized traffic against the model
    applyStimulus(600);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
